// File: rtl/obuf_writeback_if.sv
// ----------------------------------------------------------------------------
// obuf_writeback_if
//
// Bundle of every signal between obuf_writeback and its neighbours:
//   - tile control from control_unit: start, acc_en, flush, relu_en,
//     output_base_addr; status back: busy, tile_done, wb_done, collect_err
//   - skewed partial sums from the PE array: psum_in, psum_valid
//   - memory write port: mem_wr_en, mem_addr, mem_wdata, mem_ready
//
// Modports:
//   master - the environment side (control_unit, PE array, memory)
//   slave  - the obuf_writeback stage itself
// ----------------------------------------------------------------------------
interface obuf_writeback_if #(
  parameter int DATA_W     = 32,
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_W     = 10
);

  // tile control / status
  logic                               start;
  logic                               acc_en;
  logic                               flush;
  logic                               relu_en;
  logic [ADDR_W-1:0]                  output_base_addr;
  logic                               busy;
  logic                               tile_done;
  logic                               wb_done;
  logic                               collect_err;

  // PE array results, one signed value per column
  logic [ARRAY_SIZE-1:0][DATA_W-1:0]  psum_in;
  logic [ARRAY_SIZE-1:0]              psum_valid;

  // memory write port, one 32-bit word per OBUF element
  logic                               mem_ready;
  logic                               mem_wr_en;
  logic [31:0]                        mem_addr;
  logic [31:0]                        mem_wdata;

  modport master (
    output start, acc_en, flush, relu_en, output_base_addr,
    output psum_in, psum_valid,
    output mem_ready,
    input  busy, tile_done, wb_done, collect_err,
    input  mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    input  start, acc_en, flush, relu_en, output_base_addr,
    input  psum_in, psum_valid,
    input  mem_ready,
    output busy, tile_done, wb_done, collect_err,
    output mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/obuf_writeback.sv
// ----------------------------------------------------------------------------
// obuf_writeback
//
// Output stage behind the systolic PE array. Each column of the array emits
// ARRAY_SIZE partial sums (one per row, column c lagging column c-1 by a
// cycle). They are captured into an ARRAY_SIZE x ARRAY_SIZE output buffer,
// optionally accumulated on top of the previous K-tile, and - when flush is
// requested - written to memory row-major starting at output_base_addr, with
// an optional ReLU applied to each word on the way out.
//
// Ports:
//   clk  - clock
//   nRST - asynchronous, active-low reset
//   bus  - obuf_writeback_if.slave: tile control/status, per-column psums
//          with valids, and the 32-bit memory write port
//
// Parameters:
//   DATA_W     - OBUF element width, must equal the 32-bit memory word
//   ARRAY_SIZE - PE array rows/columns (at least 2)
//   ADDR_W     - width of output_base_addr
// ----------------------------------------------------------------------------
module obuf_writeback #(
  parameter int DATA_W     = 32,
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              nRST,
  obuf_writeback_if.slave   bus
);

  // col_cnt must be able to hold ARRAY_SIZE itself ("column full")
  localparam int CNT_W = $clog2(ARRAY_SIZE + 1);
  localparam int ROW_W = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WRITEBACK = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;

  logic [DATA_W-1:0]   obuf    [ARRAY_SIZE][ARRAY_SIZE];
  logic [CNT_W-1:0]    col_cnt [ARRAY_SIZE];

  logic                flush_q;
  logic                relu_q;
  logic [ADDR_W-1:0]   base_q;
  logic                collect_err_q;

  logic [ROW_W-1:0]    wr_row;
  logic [ROW_W-1:0]    wr_col;

  logic                start_tile;
  logic                tile_full;
  logic                overflow;
  logic                last_write;
  logic                transfer;
  logic [DATA_W-1:0]   rd_elem;

  // A tile only starts from IDLE; start seen in any other state is ignored.
  assign start_tile = (state == IDLE) && bus.start;
  assign transfer   = (state == WRITEBACK) && bus.mem_ready;
  assign last_write = (wr_row == ROW_W'(ARRAY_SIZE - 1)) &&
                      (wr_col == ROW_W'(ARRAY_SIZE - 1));

  // Column bookkeeping. tile_full looks at the registered counters, so the
  // FSM leaves COLLECT on the edge after the last capture. overflow flags a
  // valid arriving on a column that already holds ARRAY_SIZE results.
  always_comb begin
    tile_full = 1'b1;
    overflow  = 1'b0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      if (col_cnt[c] != CNT_W'(ARRAY_SIZE)) begin
        tile_full = 1'b0;
      end
      if (bus.psum_valid[c] && (col_cnt[c] == CNT_W'(ARRAY_SIZE))) begin
        overflow = 1'b1;
      end
    end
  end

  // State register. Reset forces IDLE asynchronously, which also drops
  // mem_wr_en straight away since the write strobe is decoded from state.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Writeback only happens when the tile was started with
  // flush set; otherwise the tile goes straight to the one-cycle DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        if (tile_full) begin
          next_state = flush_q ? WRITEBACK : DONE;
        end
      end
      WRITEBACK: begin
        if (bus.mem_ready && last_write) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Per-tile controls are captured at start so control_unit may move on to
  // the next tile's settings while this one is still running. acc_en only
  // matters on the start edge itself (it decides whether OBUF is cleared),
  // so it does not need to be held.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      flush_q <= 1'b0;
      relu_q  <= 1'b0;
      base_q  <= '0;
    end else if (start_tile) begin
      flush_q <= bus.flush;
      relu_q  <= bus.relu_en;
      base_q  <= bus.output_base_addr;
    end
  end

  // Buffer and column counters. Each column walks its own row pointer, so
  // skewed or bubbly arrival needs no alignment. Adds wrap modulo 2^DATA_W.
  // Once a column is full further data on it is dropped.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        for (int c = 0; c < ARRAY_SIZE; c++) begin
          obuf[r][c] <= '0;
        end
      end
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        col_cnt[c] <= '0;
      end
    end else if (start_tile) begin
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        col_cnt[c] <= '0;
      end
      if (!bus.acc_en) begin
        for (int r = 0; r < ARRAY_SIZE; r++) begin
          for (int c = 0; c < ARRAY_SIZE; c++) begin
            obuf[r][c] <= '0;
          end
        end
      end
    end else if (state == COLLECT) begin
      for (int c = 0; c < ARRAY_SIZE; c++) begin
        if (bus.psum_valid[c] && (col_cnt[c] < CNT_W'(ARRAY_SIZE))) begin
          obuf[col_cnt[c][ROW_W-1:0]][c] <=
            obuf[col_cnt[c][ROW_W-1:0]][c] + bus.psum_in[c];
          col_cnt[c] <= col_cnt[c] + 1'b1;
        end
      end
    end
  end

  // Sticky overflow flag: set by any dropped psum during COLLECT, held
  // through writeback and DONE, cleared only when the next tile starts.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      collect_err_q <= 1'b0;
    end else if (start_tile) begin
      collect_err_q <= 1'b0;
    end else if ((state == COLLECT) && overflow) begin
      collect_err_q <= 1'b1;
    end
  end

  // Writeback pointer, kept as row/column so no divide is needed to address
  // OBUF. It only moves on an accepted transfer, which keeps address and
  // data stable while memory stalls.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (start_tile) begin
      wr_row <= '0;
      wr_col <= '0;
    end else if (transfer) begin
      if (wr_col == ROW_W'(ARRAY_SIZE - 1)) begin
        wr_col <= '0;
        wr_row <= last_write ? '0 : wr_row + 1'b1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  // Memory port and status outputs, all decoded from state so they are zero
  // outside the phases that use them.
  assign rd_elem = obuf[wr_row][wr_col];

  always_comb begin
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == WRITEBACK) begin
      bus.mem_wr_en = 1'b1;
      bus.mem_addr  = 32'(base_q) + (32'(wr_row) * 32'(ARRAY_SIZE)) +
                      32'(wr_col);
      // ReLU: any element with its sign bit set goes out as zero
      bus.mem_wdata = (relu_q && rd_elem[DATA_W-1]) ? '0 : rd_elem;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.tile_done   = (state == DONE);
  assign bus.wb_done     = (state == DONE) && flush_q;
  assign bus.collect_err = collect_err_q;

endmodule

// File: tb/tb_obuf_writeback.sv
// ----------------------------------------------------------------------------
// tb_obuf_writeback
//
// Self-checking bench for obuf_writeback. A reference OBUF is kept as a
// plain 2-D array: cleared or kept at start depending on acc_en, each fed
// psum added to its (row, column) slot, and the expected memory image is
// base + row*N + col with optional ReLU. A monitor records every accepted
// write and checks that address/data hold while memory stalls.
// ----------------------------------------------------------------------------
module tb_obuf_writeback;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk  = 1'b0;
  logic nRST = 1'b0;

  always #5 clk = ~clk;

  obuf_writeback_if #(.DATA_W(DW), .ARRAY_SIZE(N), .ADDR_W(AW)) bus ();

  obuf_writeback #(.DATA_W(DW), .ARRAY_SIZE(N), .ADDR_W(AW)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]   ref_obuf  [N][N];
  logic [31:0]   tile_vals [N][N];
  logic          exp_flush;
  logic          exp_relu;
  logic [AW-1:0] exp_base;

  logic [31:0]   wr_addr_q [$];
  logic [31:0]   wr_data_q [$];

  int            ready_mode  = 0;
  int            ready_phase = 0;

  logic          stalled_prev = 1'b0;
  logic [31:0]   stall_addr   = '0;
  logic [31:0]   stall_data   = '0;

  // Memory-side monitor, sampled mid-cycle: records transfers and checks
  // that a stalled write presents the same address and data next cycle.
  always @(negedge clk) begin
    if (bus.mem_wr_en && stalled_prev) begin
      checks++;
      if (bus.mem_addr !== stall_addr || bus.mem_wdata !== stall_data) begin
        failures++;
        $display("[TB] FAIL stall_hold addr=%h data=%h required addr=%h data=%h",
                 bus.mem_addr, bus.mem_wdata, stall_addr, stall_data);
      end
    end
    if (bus.mem_wr_en && bus.mem_ready) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    stalled_prev = bus.mem_wr_en && !bus.mem_ready;
    stall_addr   = bus.mem_addr;
    stall_data   = bus.mem_wdata;
  end

  // Memory ready generator: always ready, a 1,0,0 pattern, or random.
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_phase++;
      case (ready_mode)
        0:       bus.mem_ready = 1'b1;
        1:       bus.mem_ready = (ready_phase % 3 == 0);
        default: bus.mem_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic fill_const(input logic [31:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        tile_vals[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        tile_vals[r][c] = $urandom;
  endtask

  // Issue a one-cycle start, then scramble the control inputs to show the
  // DUT works from its latched copy.
  task automatic start_tile(input logic acc, input logic fl, input logic relu,
                            input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    bus.start            = 1'b1;
    bus.acc_en           = acc;
    bus.flush            = fl;
    bus.relu_en          = relu;
    bus.output_base_addr = base;
    @(posedge clk);
    #1;
    bus.start            = 1'b0;
    bus.psum_valid       = '0;
    bus.acc_en           = 1'($urandom);
    bus.flush            = 1'($urandom);
    bus.relu_en          = 1'($urandom);
    bus.output_base_addr = AW'($urandom);
    if (!acc) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          ref_obuf[r][c] = '0;
    end
    exp_flush = fl;
    exp_relu  = relu;
    exp_base  = base;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Feed tile_vals into the columns in mask, column c starting c cycles late,
  // optionally with random bubbles. Ends #1 after the last capture edge.
  task automatic feed_tile(input logic [N-1:0] mask, input bit bubbles);
    int  ptr [N];
    int  t;
    bit  all_done;
    for (int c = 0; c < N; c++) ptr[c] = mask[c] ? 0 : N;
    t = 0;
    @(posedge clk);
    #1;
    while (1) begin
      all_done = 1'b1;
      for (int c = 0; c < N; c++) if (ptr[c] < N) all_done = 1'b0;
      if (all_done || t > 200) break;
      for (int c = 0; c < N; c++) begin
        bus.psum_valid[c] = 1'b0;
        bus.psum_in[c]    = $urandom;
        if (ptr[c] < N && t >= c && (!bubbles || $urandom_range(0, 3) != 0)) begin
          bus.psum_valid[c] = 1'b1;
          bus.psum_in[c]    = tile_vals[ptr[c]][c];
          ref_obuf[ptr[c]][c] = ref_obuf[ptr[c]][c] + tile_vals[ptr[c]][c];
          ptr[c]++;
        end
      end
      @(posedge clk);
      #1;
      t++;
    end
    bus.psum_valid = '0;
  endtask

  // Wait for busy to drop (bounded), tallying pulses and write-cycle timing
  // relative to the first sampled cycle.
  task automatic wait_done(output int n_tile, output int n_wb, output int n_wr,
                           output int first_wr, output int last_wr,
                           output int done_k, output bit timeout);
    int k;
    n_tile = 0; n_wb = 0; n_wr = 0;
    first_wr = -1; last_wr = -1; done_k = -1;
    timeout = 1'b1;
    k = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.mem_wr_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = k;
        last_wr = k;
      end
      if (bus.tile_done) begin n_tile++; done_k = k; end
      if (bus.wb_done) n_wb++;
      if (!bus.busy) begin timeout = 1'b0; break; end
      k++;
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.tile_done) n_tile++;
      if (bus.wb_done) n_wb++;
    end
  endtask

  task automatic check_end(input string name, input bit timeout,
                           input int n_tile, input int n_wb);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_timeout busy never dropped", name);
    end
    checks++;
    if (n_tile != 1) begin
      failures++;
      $display("[TB] FAIL %s_tile_done pulses=%0d required=1", name, n_tile);
    end
    checks++;
    if (n_wb != (exp_flush ? 1 : 0)) begin
      failures++;
      $display("[TB] FAIL %s_wb_done pulses=%0d required=%0d", name, n_wb,
               exp_flush ? 1 : 0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_busy got=%b required=0", name, bus.busy);
    end
  endtask

  task automatic check_writes(input string name);
    int          exp_n;
    logic [31:0] ea;
    logic [31:0] ed;
    exp_n = exp_flush ? N * N : 0;
    checks++;
    if (wr_addr_q.size() != exp_n) begin
      failures++;
      $display("[TB] FAIL %s_count writes=%0d required=%0d", name,
               wr_addr_q.size(), exp_n);
    end
    for (int i = 0; i < N * N && i < wr_addr_q.size(); i++) begin
      ea = 32'(exp_base) + 32'(i);
      ed = ref_obuf[i / N][i % N];
      if (exp_relu && ed[31]) ed = '0;
      checks++;
      if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) begin
        failures++;
        $display("[TB] FAIL %s_word%0d addr=%h data=%h required addr=%h data=%h",
                 name, i, wr_addr_q[i], wr_data_q[i], ea, ed);
      end
    end
  endtask

  task automatic check_outputs_idle(input string name);
    checks++;
    if (bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.mem_wdata !== 32'h0 || bus.busy !== 1'b0 ||
        bus.tile_done !== 1'b0 || bus.wb_done !== 1'b0 ||
        bus.collect_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s outputs wr=%b addr=%h data=%h busy=%b td=%b wd=%b err=%b required all 0",
               name, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata, bus.busy,
               bus.tile_done, bus.wb_done, bus.collect_err);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.acc_en = 1'b0; bus.flush = 1'b0; bus.relu_en = 1'b0;
    bus.output_base_addr = '0; bus.psum_in = '0; bus.psum_valid = '0;
    nRST = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ref_obuf[r][c] = '0;
    repeat (3) @(negedge clk);
    check_outputs_idle("reset_held");
    #2;
    nRST = 1'b1;
    @(negedge clk);
    check_outputs_idle("reset_released");
  endtask

  task automatic test_basic();
    int n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit timeout;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        tile_vals[r][c] = 32'(10 * r + c);
    start_tile(1'b0, 1'b1, 1'b0, 10'h040);
    feed_tile('1, 1'b0);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("basic", timeout, n_tile, n_wb);
    check_writes("basic");
    checks++;
    if (wr_data_q.size() < 6 || wr_addr_q[5] !== 32'h045 || wr_data_q[5] !== 32'd11) begin
      failures++;
      $display("[TB] FAIL basic_addr45 writes=%0d required word 0x045 = 11",
               wr_data_q.size());
    end
    checks++;
    if (first_wr != 1 || n_wr != N * N || last_wr != first_wr + N * N - 1 ||
        done_k != last_wr + 1) begin
      failures++;
      $display("[TB] FAIL basic_latency first=%0d n=%0d last=%0d done=%0d required 1/16/16/17",
               first_wr, n_wr, last_wr, done_k);
    end
  endtask

  task automatic test_accumulate();
    int n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit timeout;
    fill_const(32'd5);
    start_tile(1'b0, 1'b0, 1'b0, 10'h080);
    feed_tile('1, 1'b0);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("acc_first", timeout, n_tile, n_wb);
    checks++;
    if (n_wr != 0) begin
      failures++;
      $display("[TB] FAIL acc_first_no_write write_cycles=%0d required=0", n_wr);
    end
    fill_const(32'd7);
    start_tile(1'b1, 1'b1, 1'b0, 10'h080);
    feed_tile('1, 1'b1);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("acc_second", timeout, n_tile, n_wb);
    checks++;
    if (wr_data_q.size() != N * N || wr_data_q[N * N - 1] !== 32'd12) begin
      failures++;
      $display("[TB] FAIL acc_twelve writes=%0d required 16 words of 12",
               wr_data_q.size());
    end
    check_writes("acc_second");
  endtask

  task automatic test_relu();
    int n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit timeout;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        tile_vals[r][c] = (r == 0) ? 32'hFFFF_FFFD : 32'd3;
    start_tile(1'b0, 1'b1, 1'b1, 10'h100);
    feed_tile('1, 1'b0);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("relu", timeout, n_tile, n_wb);
    checks++;
    if (wr_data_q.size() != N * N || wr_data_q[0] !== 32'd0 || wr_data_q[N] !== 32'd3) begin
      failures++;
      $display("[TB] FAIL relu_clamp writes=%0d required word0=0 word4=3",
               wr_data_q.size());
    end
    check_writes("relu");
    fill_random();
    start_tile(1'b1, 1'b1, 1'b1, 10'h1F0);
    feed_tile('1, 1'b1);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("relu_rand", timeout, n_tile, n_wb);
    check_writes("relu_rand");
  endtask

  task automatic test_stall();
    int n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit timeout;
    fill_random();
    ready_mode = 1;
    start_tile(1'b0, 1'b1, 1'b0, 10'h200);
    feed_tile('1, 1'b1);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    ready_mode = 0;
    check_end("stall", timeout, n_tile, n_wb);
    check_writes("stall");
    checks++;
    if (n_wr <= N * N) begin
      failures++;
      $display("[TB] FAIL stall_cycles write_cycles=%0d required more than 16", n_wr);
    end
  endtask

  task automatic test_overflow();
    int n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit timeout;
    fill_random();
    start_tile(1'b0, 1'b1, 1'b0, 10'h300);
    feed_tile(4'b0111, 1'b0);
    bus.psum_valid[2] = 1'b1;
    bus.psum_in[2]    = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.psum_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.collect_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_flag got=%b required=1", bus.collect_err);
    end
    feed_tile(4'b1000, 1'b0);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("overflow", timeout, n_tile, n_wb);
    check_writes("overflow");
    checks++;
    if (bus.collect_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overflow_sticky got=%b required=1", bus.collect_err);
    end
    fill_const(32'd0);
    start_tile(1'b1, 1'b0, 1'b0, 10'h300);
    @(negedge clk);
    checks++;
    if (bus.collect_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow_clear got=%b required=0", bus.collect_err);
    end
    feed_tile('1, 1'b0);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("overflow_next", timeout, n_tile, n_wb);
  endtask

  task automatic test_reset_midway();
    int  n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit  timeout;
    bit  found;
    fill_random();
    start_tile(1'b0, 1'b1, 1'b0, 10'h050);
    feed_tile('1, 1'b0);
    found = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.mem_wr_en && bus.mem_addr == 32'h057) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL midreset_reach write index 7 never presented");
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (bus.mem_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_abort wr=%b busy=%b required 0/0",
               bus.mem_wr_en, bus.busy);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        ref_obuf[r][c] = '0;
    @(negedge clk);
    #2;
    nRST = 1'b1;
    fill_random();
    start_tile(1'b1, 1'b1, 1'b0, 10'h060);
    feed_tile('1, 1'b1);
    wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
    check_end("midreset_after", timeout, n_tile, n_wb);
    check_writes("midreset_after");
  endtask

  task automatic test_back_to_back();
    int          n_tile, n_wb, n_wr, first_wr, last_wr, done_k;
    bit          timeout;
    logic [2:0]  flags;
    for (int it = 0; it < 5; it++) begin
      flags      = 3'($urandom);
      ready_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      fill_random();
      // stray valids while IDLE must neither load data nor raise an error
      repeat (2) begin
        @(posedge clk);
        #1;
        bus.psum_valid = N'($urandom);
        bus.psum_in    = {N{32'hDEAD_0001}};
      end
      start_tile(flags[0], flags[1] | (it == 4), flags[2], AW'($urandom_range(0, 1000)));
      feed_tile('1, 1'b1);
      wait_done(n_tile, n_wb, n_wr, first_wr, last_wr, done_k, timeout);
      check_end("b2b", timeout, n_tile, n_wb);
      check_writes("b2b");
      checks++;
      if (bus.collect_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_err iter=%0d got=%b required=0", it, bus.collect_err);
      end
    end
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_relu();
    test_stall();
    test_overflow();
    test_reset_midway();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
